// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer: FSM states and the buffered store entry.
package dmem_pkg;

    // Entry address field is sized for the widest supported byte address (AW = 32).
    localparam int SB_WADDR_W = 30;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        RESP
    } sb_state_e;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] addr;
        logic [31:0]           data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: entry storage, head/tail pointers and occupancy count.
// With SB_FORWARD_EN defined it also searches for the newest entry matching a load address.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  sb_entry_t             push_entry,
    input  logic                  pop,
    output sb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic                  full
`ifdef SB_FORWARD_EN
    ,
    input  logic [SB_WADDR_W-1:0] lookup_addr,
    output logic                  hit,
    output logic [31:0]           hit_data
`endif
);

    sb_entry_t     mem_q [DEPTH];
    sb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are PW bits wide, so incrementing past DEPTH-1 wraps to 0.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));

`ifdef SB_FORWARD_EN
    logic [PW-1:0] idx;

    // Scan oldest to newest so that the last (newest) valid match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = mem_q[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory front end: posts CPU stores into a FIFO, drains them to a handshaked word RAM
// and serves loads, stalling the CPU on RAM fetches. Define SB_FORWARD_EN for store-to-load forwarding.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MRead,
    input  logic          MWrite,
    input  logic [AW-1:0] Maddr,
    input  logic [31:0]   Mdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    input  logic          ram_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_e             state_q, state_d;
    logic [31:0]           ld_q, ld_d;
    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [AW-3:0]         ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;

    logic [SB_WADDR_W-1:0] req_waddr;
    sb_entry_t             push_entry;
    sb_entry_t             head;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  fwd_hit;
    logic [31:0]           fwd_data;
    logic                  idle_load;
    logic                  drain_load;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^Maddr[1:0];
    assign req_waddr        = SB_WADDR_W'(Maddr[AW-1:2]);
    assign push_entry       = '{addr: req_waddr, data: Mdata};
    assign empty            = (count == '0);

    // A simultaneous load and store is treated as a load; the store is dropped.
    assign push = MWrite & ~MRead & ~full;

    sb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full)
`ifdef SB_FORWARD_EN
        ,
        .lookup_addr(req_waddr),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
`endif
    );

`ifdef SB_FORWARD_EN
    // A miss never overlaps a buffered entry, so the RAM read may bypass pending stores.
    assign idle_load  = MRead & ~fwd_hit;
    assign drain_load = MRead & ~fwd_hit;
`else
    // Without forwarding, RAM is only read once the buffer has fully drained.
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign idle_load  = MRead & empty;
    assign drain_load = MRead & (count == CW'(1));
`endif

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_load) begin
                    state_d = LOAD;
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ram_ready) begin
                    pop     = 1'b1;
                    state_d = drain_load ? LOAD : IDLE;
                end
            end
            LOAD: begin
                if (ram_ready) begin
                    ld_d    = ram_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM-side outputs are registered from the next state, keeping CPU inputs off the RAM paths.
    always_comb begin
        ram_req_d   = (state_d == DRAIN) || (state_d == LOAD);
        ram_we_d    = (state_d == DRAIN);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_d == DRAIN) begin
            ram_addr_d  = head.addr[AW-3:0];
            ram_wdata_d = head.data;
        end else if (state_d == LOAD) begin
            ram_addr_d  = Maddr[AW-1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_q        <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // A full buffer stalls stores even in the cycle its head completes.
    always_comb begin
        stall = 1'b0;
        rdata = '0;
        if (MRead) begin
            if (state_q == RESP) begin
                rdata = ld_q;
            end else if (fwd_hit) begin
                rdata = fwd_data;
            end else begin
                stall = 1'b1;
            end
        end else if (MWrite) begin
            stall = full;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed testbench for dmem_store_buffer with a word RAM model whose wait states can be
// configured or held off; expectations follow SB_FORWARD_EN when it is defined.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          MRead;
    logic          MWrite;
    logic [AW-1:0] Maddr;
    logic [31:0]   Mdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          ram_req;
    logic          ram_we;
    logic [AW-3:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          ram_ready;

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            wait_cfg     = 0;
    bit            hold_ready   = 1'b0;
    int            wait_cnt     = 0;
    logic [31:0]   ram_mem [256];
    int            log_count    = 0;
    logic [29:0]   log_addr [32];
    logic [31:0]   log_data [32];

    dmem_store_buffer #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MRead    (MRead),
        .MWrite   (MWrite),
        .Maddr    (Maddr),
        .Mdata    (Mdata),
        .rdata    (rdata),
        .stall    (stall),
        .ram_req  (ram_req),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    // RAM model: completes after wait_cfg wait cycles unless hold_ready blocks it.
    assign ram_ready = ram_req && !hold_ready && (wait_cnt >= wait_cfg);
    assign ram_rdata = ram_ready ? ram_mem[ram_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
            ram_mem[8'hC0] = 32'h1234_5678;
            ram_mem[8'hFC] = 32'h0BAD_F00D;
        end else if (ram_req && ram_ready) begin
            wait_cnt <= 0;
            if (ram_we) begin
                ram_mem[ram_addr[7:0]] = ram_wdata;
                if (log_count < 32) begin
                    log_addr[log_count] = ram_addr[29:0];
                    log_data[log_count] = ram_wdata;
                end
                log_count = log_count + 1;
            end
        end else if (ram_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        MRead  = rd;
        MWrite = wr;
        Maddr  = addr;
        Mdata  = data;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    task automatic waitStallLow(output int n);
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int log_start;
        rst    = 1'b1;
        MRead  = 1'b0;
        MWrite = 1'b0;
        Maddr  = '0;
        Mdata  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_stall", 64'(stall), 64'(0));
        checkOutput("reset_rdata", 64'(rdata), 64'(0));
        checkOutput("reset_ram_req", 64'(ram_req), 64'(0));
        checkOutput("reset_ram_we", 64'(ram_we), 64'(0));
        checkOutput("reset_ram_addr", 64'(ram_addr), 64'(0));
        checkOutput("reset_ram_wdata", 64'(ram_wdata), 64'(0));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            if (ram_req !== 1'b0) n++;
        end
        checkOutput("idle_ram_req_cycles", 64'(n), 64'(0));

        // Store then load of the same word.
        log_start = log_count;
        applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        checkOutput("store_no_stall", 64'(stall), 64'(0));
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0);
        waitStallLow(n);
        checkOutput("hit_stall_cycles", 64'(n), 64'(FWD ? 0 : 3));
        checkOutput("hit_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
        idleCycles(6);
        checkOutput("drain_ram_word", 64'(ram_mem[8'h40]), 64'h0000_0000_DEAD_BEEF);
        checkOutput("drain_log_addr", 64'(log_addr[log_start]), 64'h40);

        // Two stores to one word, then a load must see the newer one.
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h2);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0);
        waitStallLow(n);
        checkOutput("newest_stall_cycles", 64'(n), 64'(FWD ? 0 : 4));
        checkOutput("newest_rdata", 64'(rdata), 64'h2);
        idleCycles(8);

        // Fill the buffer with RAM blocked; the fifth store waits for the first completion.
        hold_ready = 1'b1;
        log_start  = log_count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
            checkOutput("fill_stall", 64'(stall), 64'(i == 4));
        end
        checkOutput("fill_ram_req", 64'(ram_req), 64'(1));
        checkOutput("fill_ram_we", 64'(ram_we), 64'(1));
        checkOutput("fill_ram_addr", 64'(ram_addr), 64'h4);
        checkOutput("fill_ram_wdata", 64'(ram_wdata), 64'hA0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h20, 32'hA4);
            checkOutput("full_hold_stall", 64'(stall), 64'(1));
        end
        hold_ready = 1'b0;
        #1;
        checkOutput("full_pop_cycle_stall", 64'(stall), 64'(1));
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hA4);
        checkOutput("full_released_stall", 64'(stall), 64'(0));
        idleCycles(16);
        checkOutput("fill_write_count", 64'(log_count - log_start), 64'(5));
        for (int i = 0; i < 5; i++) begin
            checkOutput("fill_order_addr", 64'(log_addr[log_start + i]), 64'(4 + i));
            checkOutput("fill_order_data", 64'(log_data[log_start + i]), 64'(32'hA0 + 32'(i)));
        end

        // Load miss with two RAM wait states.
        wait_cfg = 2;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0);
        waitStallLow(n);
        checkOutput("miss_stall_cycles", 64'(n), 64'(4));
        checkOutput("miss_rdata", 64'(rdata), 64'h1234_5678);
        idleCycles(2);

        // Reset while a drain is outstanding drops the buffered store.
        wait_cfg   = 0;
        hold_ready = 1'b1;
        log_start  = log_count;
        applyStimulus(1'b0, 1'b1, 32'h3F0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("pre_rst_ram_req", 64'(ram_req), 64'(1));
        checkOutput("pre_rst_ram_we", 64'(ram_we), 64'(1));
        checkOutput("pre_rst_ram_addr", 64'(ram_addr), 64'hFC);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hold_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ram_req", 64'(ram_req), 64'(0));
        checkOutput("post_rst_stall", 64'(stall), 64'(0));
        n = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            if (ram_req !== 1'b0) n++;
        end
        checkOutput("post_rst_idle_req", 64'(n), 64'(0));
        applyStimulus(1'b1, 1'b0, 32'h3F0, 32'h0);
        waitStallLow(n);
        checkOutput("post_rst_load_stall", 64'(n), 64'(2));
        checkOutput("post_rst_load_rdata", 64'(rdata), 64'h0BAD_F00D);
        checkOutput("post_rst_no_write", 64'(log_count - log_start), 64'(0));
        idleCycles(2);

        // Load and store together: served as a load, store discarded.
        log_start = log_count;
        applyStimulus(1'b1, 1'b1, 32'h300, 32'hFFFF_FFFF);
        waitStallLow(n);
        checkOutput("both_stall_cycles", 64'(n), 64'(2));
        checkOutput("both_rdata", 64'(rdata), 64'h1234_5678);
        idleCycles(6);
        checkOutput("both_no_write", 64'(log_count - log_start), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
